// File: rtl/alu_result_skid_if.sv
// Handshake and payload bundle between the ALU and the result skid buffer.
// The slave view belongs to the buffer; the master view drives it.
interface alu_result_skid_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        in_setflags;
    logic [3:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_regwrite;
    logic [3:0]  flags;

    modport slave (
        input  in_valid, in_result, in_rd, in_regwrite, in_setflags, in_flags, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_regwrite, flags
    );

    modport master (
        output in_valid, in_result, in_rd, in_regwrite, in_setflags, in_flags, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_regwrite, flags
    );
endinterface

// File: rtl/alu_result_skid.sv
// Two-entry in-order result buffer (head + skid) between the ALU and writeback.
// in_ready is registered so the upstream never sees a path from out_ready.
module alu_result_skid (
    input  logic               clk,
    input  logic               reset,
    alu_result_skid_if.slave   bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        in_ready_reg;
    logic [3:0]  flags_reg;

    logic [63:0] head_result_reg, skid_result_reg;
    logic [4:0]  head_rd_reg, skid_rd_reg;
    logic        head_regwrite_reg, skid_regwrite_reg;

    logic        in_xfer, out_xfer;
    logic        head_load_in, head_load_skid, skid_load;
    logic        entry_regwrite;

    // Writes to XZR are dropped at capture time so downstream never sees them.
    assign entry_regwrite = bus.in_regwrite && (bus.in_rd != 5'd31);
    assign in_xfer        = bus.in_valid && in_ready_reg;
    assign out_xfer       = (state_reg != EMPTY) && bus.out_ready;

    always_comb begin
        state_next     = state_reg;
        head_load_in   = 1'b0;
        head_load_skid = 1'b0;
        skid_load      = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (in_xfer) begin
                    state_next   = ONE;
                    head_load_in = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    head_load_in = 1'b1;
                end else if (in_xfer) begin
                    state_next = TWO;
                    skid_load  = 1'b1;
                end else if (out_xfer) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the drain side can move.
                if (out_xfer) begin
                    state_next     = ONE;
                    head_load_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= EMPTY;
            in_ready_reg <= 1'b0;
            flags_reg    <= 4'b0000;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != TWO);
            if (in_xfer && bus.in_setflags) begin
                flags_reg <= bus.in_flags;
            end
        end
    end

    // Payload needs no reset: out_regwrite is qualified by out_valid below.
    always_ff @(posedge clk) begin
        if (head_load_in) begin
            head_result_reg   <= bus.in_result;
            head_rd_reg       <= bus.in_rd;
            head_regwrite_reg <= entry_regwrite;
        end else if (head_load_skid) begin
            head_result_reg   <= skid_result_reg;
            head_rd_reg       <= skid_rd_reg;
            head_regwrite_reg <= skid_regwrite_reg;
        end
        if (skid_load) begin
            skid_result_reg   <= bus.in_result;
            skid_rd_reg       <= bus.in_rd;
            skid_regwrite_reg <= entry_regwrite;
        end
    end

    assign bus.in_ready     = in_ready_reg;
    assign bus.out_valid    = (state_reg != EMPTY);
    assign bus.out_result   = head_result_reg;
    assign bus.out_rd       = head_rd_reg;
    assign bus.out_regwrite = head_regwrite_reg && (state_reg != EMPTY);
    assign bus.flags        = flags_reg;
endmodule

// File: doc/alu_result_skid.md
ALU_RESULT_SKID -- requirements
Module: alu_result_skid

Interface
REQ-001 The module SHALL have a single clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream ALU presents a result this cycle.
REQ-005 in_ready  output  1  block can accept an entry this cycle.
REQ-006 in_result  input  64  ALU result.
REQ-007 in_rd  input  5  destination register index.
REQ-008 in_regwrite  input  1  result is to be written back.
REQ-009 in_setflags  input  1  entry updates the flag register (ADDS/SUBS/ANDS).
REQ-010 in_flags  input  4  {N,Z,V,C} produced by the ALU.
REQ-011 out_valid  output  1  an entry is presented downstream.
REQ-012 out_ready  input  1  downstream accepts the presented entry.
REQ-013 out_result  output  64  result of the head entry.
REQ-014 out_rd  output  5  rd of the head entry.
REQ-015 out_regwrite  output  1  regwrite of the head entry, after the XZR rule.
REQ-016 flags  output  4  committed {N,Z,V,C} flag register.

Function
REQ-017 Input transfer occurs iff in_valid && in_ready at a rising edge; output transfer occurs iff out_valid && out_ready at a rising edge.
REQ-018 Storage SHALL be a 2-entry in-order buffer (head register + skid register); entries leave in acceptance order.
REQ-019 States SHALL be EMPTY (0 entries), ONE (1), TWO (2); out_valid = (state != EMPTY).
REQ-020 in_ready SHALL be a registered signal equal to (state != TWO) and SHALL NOT combinationally depend on out_ready.
REQ-021 Transitions: EMPTY to ONE on input; ONE to TWO on input without output; ONE to EMPTY on output without input; ONE stays ONE on simultaneous input and output (new entry becomes head next cycle); TWO to ONE on output (skid moves to head); TWO ignores in_valid.
REQ-022 Latency: an entry accepted in EMPTY SHALL appear on out_* the next cycle.
REQ-023 out_* SHALL hold stable while out_valid && !out_ready.
REQ-024 An entry with in_rd == 31 (XZR) SHALL be stored with regwrite forced to 0; result and rd are still stored unchanged.
REQ-025 flags SHALL load in_flags on the edge of an input transfer with in_setflags = 1, independent of buffer state and output activity; otherwise flags hold.
REQ-026 in_valid while in_ready = 0 SHALL change no state, including flags.
REQ-027 Head/skid payload contents when out_valid = 0 are don't-care, but out_regwrite SHALL be 0 whenever out_valid = 0.

Reset
REQ-028 While reset is asserted: state = EMPTY, out_valid = 0, out_regwrite = 0, in_ready = 0, flags = 4'b0000, taking effect immediately without a clock edge.
REQ-029 in_ready SHALL rise on the first rising edge after reset deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries; no entry is delivered after reset.

Verification
REQ-031 Reset, then one input {result=64'h0F, rd=3, regwrite=1} with out_ready=1 -> out_valid=1 next cycle with out_result=64'h0F, out_rd=3, out_regwrite=1; then EMPTY.
REQ-032 out_ready=0, three back-to-back inputs A=1, B=2, C=3 -> A and B accepted, in_ready=0 from the cycle after B, C not accepted; then out_ready=1 -> outputs 1, 2 in order, and C (held valid) is accepted once in_ready returns.
REQ-033 Streaming with in_valid=1 and out_ready=1 for 8 cycles (results 0..7) -> state stays ONE, outputs 0..7 in order one per cycle, in_ready stays 1.
REQ-034 Input {rd=31, regwrite=1, result=64'hFF} -> out_regwrite=0, out_rd=31, out_result=64'hFF.
REQ-035 Input {setflags=1, flags=4'b0100} then {setflags=0, flags=4'b1111} -> flags=4'b0100 after the first accept and unchanged after the second; flags update even while out_ready=0.
REQ-036 State TWO with out_ready=0, assert reset for one cycle asynchronously -> out_valid=0, flags=0 immediately; no prior entry appears afterwards.
